// File: rtl/spm_cdma_pkg.sv
// spm_cdma_pkg: shared constants for the byte-wide copy DMA engine.
//   - slave register indices
//   - CTRL / STATUS bit positions
//   - master-side FSM state encoding
package spm_cdma_pkg;

  localparam logic [2:0] REG_SRC_L  = 3'd0;
  localparam logic [2:0] REG_SRC_H  = 3'd1;
  localparam logic [2:0] REG_DST_L  = 3'd2;
  localparam logic [2:0] REG_DST_H  = 3'd3;
  localparam logic [2:0] REG_LEN_L  = 3'd4;
  localparam logic [2:0] REG_LEN_H  = 3'd5;
  localparam logic [2:0] REG_CTRL   = 3'd6;
  localparam logic [2:0] REG_STATUS = 3'd7;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQEN  = 1;
  localparam int CTRL_SRCINC = 2;
  localparam int CTRL_DSTINC = 3;
  localparam int CTRL_ABORT  = 4;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ABORTED = 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RGAP = 3'd2,
    S_WR   = 3'd3,
    S_WGAP = 3'd4
  } state_e;

endpackage

// File: rtl/spm_cdma_regs.sv
// spm_cdma_regs: Wishbone slave side of the DMA engine.
//   Decodes CPU accesses, holds CTRL mode bits and sticky STATUS flags,
//   produces registered ACK and read data, and hands start/abort pulses
//   and the raw write strobe to the top (which owns SRC/DST/LEN).
// Ports:
//   clk, rst                 clock, async active-high reset
//   s_*_i / s_dat_o, s_ack_o Wishbone slave
//   busy_i, src_i/dst_i/len_i live engine state for readback
//   done_set_i, abrt_set_i   completion events from the FSM
//   wr_o, start_o, abort_o   decoded write strobe and CTRL pulses
//   irq_en_o, src_inc_o, dst_inc_o  mode bits
//   irq_o                    done & irq_en
module spm_cdma_regs #(
  parameter int AWID = 16,
  parameter int LWID = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      s_adr_i,
  input  logic [7:0]      s_dat_i,
  input  logic            s_we_i,
  input  logic            s_cyc_i,
  input  logic            s_stb_i,
  output logic [7:0]      s_dat_o,
  output logic            s_ack_o,
  input  logic            busy_i,
  input  logic [AWID-1:0] src_i,
  input  logic [AWID-1:0] dst_i,
  input  logic [LWID-1:0] len_i,
  input  logic            done_set_i,
  input  logic            abrt_set_i,
  output logic            wr_o,
  output logic            start_o,
  output logic            abort_o,
  output logic            irq_en_o,
  output logic            src_inc_o,
  output logic            dst_inc_o,
  output logic            irq_o
);
  import spm_cdma_pkg::*;

  logic       ack_q;
  logic [7:0] dat_q;
  logic       irq_en_q, src_inc_q, dst_inc_q;
  logic       done_q, abrt_q;
  logic       ctrl_wr, stat_wr;
  logic [7:0] rdata;
  logic [15:0] src16, dst16, len16;

  // Registers narrower than 16 bits read back zero-extended.
  assign src16 = 16'(src_i);
  assign dst16 = 16'(dst_i);
  assign len16 = 16'(len_i);

  assign wr_o    = s_cyc_i & s_stb_i & s_we_i;
  assign ctrl_wr = wr_o & (s_adr_i == REG_CTRL);
  assign stat_wr = wr_o & (s_adr_i == REG_STATUS);
  assign start_o = ctrl_wr & s_dat_i[CTRL_START];
  assign abort_o = ctrl_wr & s_dat_i[CTRL_ABORT];

  assign s_ack_o   = ack_q & s_cyc_i;
  assign s_dat_o   = dat_q;
  assign irq_en_o  = irq_en_q;
  assign src_inc_o = src_inc_q;
  assign dst_inc_o = dst_inc_q;
  assign irq_o     = done_q & irq_en_q;

  always_comb begin
    rdata = 8'h00;
    case (s_adr_i)
      REG_SRC_L:  rdata = src16[7:0];
      REG_SRC_H:  rdata = src16[15:8];
      REG_DST_L:  rdata = dst16[7:0];
      REG_DST_H:  rdata = dst16[15:8];
      REG_LEN_L:  rdata = len16[7:0];
      REG_LEN_H:  rdata = len16[15:8];
      REG_CTRL: begin
        rdata[CTRL_IRQEN]  = irq_en_q;
        rdata[CTRL_SRCINC] = src_inc_q;
        rdata[CTRL_DSTINC] = dst_inc_q;
      end
      REG_STATUS: begin
        rdata[ST_BUSY]    = busy_i;
        rdata[ST_DONE]    = done_q;
        rdata[ST_ABORTED] = abrt_q;
      end
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q     <= 1'b0;
      dat_q     <= 8'h00;
      irq_en_q  <= 1'b0;
      src_inc_q <= 1'b0;
      dst_inc_q <= 1'b0;
      done_q    <= 1'b0;
      abrt_q    <= 1'b0;
    end else begin
      ack_q <= s_stb_i;
      if (s_cyc_i && s_stb_i) dat_q <= rdata;
      // Mode bits stay writable while busy.
      if (ctrl_wr) begin
        irq_en_q  <= s_dat_i[CTRL_IRQEN];
        src_inc_q <= s_dat_i[CTRL_SRCINC];
        dst_inc_q <= s_dat_i[CTRL_DSTINC];
      end
      // Set beats a same-cycle write-1-to-clear.
      done_q <= done_set_i | (done_q & ~(stat_wr & s_dat_i[ST_DONE]));
      abrt_q <= abrt_set_i | (abrt_q & ~(stat_wr & s_dat_i[ST_ABORTED]));
    end
  end

endmodule

// File: rtl/spm_cdma.sv
// spm_cdma: byte-wide copy DMA engine (Wishbone master + slave regs).
//   Reads one byte from SRC, writes it to DST, repeats LEN times, with a
//   mandatory one-cycle gap after each bus access so a trailing ACK from
//   the scratchpad is never taken as the next beat's ACK.
// Ports:
//   clk, rst            clock, async active-high reset
//   S_*                 Wishbone slave (CPU register access)
//   M_*                 Wishbone master (data movement)
//   irq                 level interrupt: STATUS.done & CTRL.irq_en
// AWID and LWID are expected to be in 9..16 (two byte registers each).
module spm_cdma #(
  parameter int AWID = 16,
  parameter int LWID = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      S_ADRi,
  input  logic [7:0]      S_DATi,
  output logic [7:0]      S_DATo,
  input  logic            S_WEi,
  input  logic            S_CYCi,
  input  logic            S_STBi,
  output logic            S_ACKo,
  output logic [AWID-1:0] M_ADRo,
  output logic [7:0]      M_DATo,
  input  logic [7:0]      M_DATi,
  output logic            M_WEo,
  output logic            M_CYCo,
  output logic            M_STBo,
  input  logic            M_ACKi,
  output logic            irq
);
  import spm_cdma_pkg::*;

  state_e          state_q;
  logic            cyc_q, stb_q, we_q, apend_q;
  logic [7:0]      buf_q;
  logic [AWID-1:0] src_q, dst_q;
  logic [LWID-1:0] len_q, len_dec;
  logic [15:0]     src16, dst16, len16;

  logic wr, start, abort, irq_en, src_inc, dst_inc;
  logic busy, abort_eff, last, done_set, abrt_set;

  assign busy      = (state_q != S_IDLE);
  assign abort_eff = apend_q | abort;
  assign len_dec   = (len_q == '0) ? '0 : len_q - LWID'(1);
  assign last      = (len_dec == '0) | abort_eff;
  assign done_set  = (state_q == S_IDLE && start && len_q == '0) ||
                     (state_q == S_WGAP && len_dec == '0 && !abort_eff);
  assign abrt_set  = (state_q == S_WGAP) && abort_eff;

  assign src16 = 16'(src_q);
  assign dst16 = 16'(dst_q);
  assign len16 = 16'(len_q);

  assign M_CYCo = cyc_q;
  assign M_STBo = stb_q;
  assign M_WEo  = we_q;
  assign M_ADRo = we_q ? dst_q : src_q;
  assign M_DATo = buf_q;

  spm_cdma_regs #(.AWID(AWID), .LWID(LWID)) u_regs (
    .clk        (clk),
    .rst        (rst),
    .s_adr_i    (S_ADRi),
    .s_dat_i    (S_DATi),
    .s_we_i     (S_WEi),
    .s_cyc_i    (S_CYCi),
    .s_stb_i    (S_STBi),
    .s_dat_o    (S_DATo),
    .s_ack_o    (S_ACKo),
    .busy_i     (busy),
    .src_i      (src_q),
    .dst_i      (dst_q),
    .len_i      (len_q),
    .done_set_i (done_set),
    .abrt_set_i (abrt_set),
    .wr_o       (wr),
    .start_o    (start),
    .abort_o    (abort),
    .irq_en_o   (irq_en),
    .src_inc_o  (src_inc),
    .dst_inc_o  (dst_inc),
    .irq_o      (irq)
  );

  // Trace-only use of irq_en keeps the port list symmetric.
  logic unused_ok;
  assign unused_ok = irq_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      apend_q <= 1'b0;
      buf_q   <= 8'h00;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
    end else begin
      // Abort only latches while a transfer is running.
      if (busy && abort) apend_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (wr) begin
            case (S_ADRi)
              REG_SRC_L: src_q <= AWID'({src16[15:8], S_DATi});
              REG_SRC_H: src_q <= AWID'({S_DATi, src16[7:0]});
              REG_DST_L: dst_q <= AWID'({dst16[15:8], S_DATi});
              REG_DST_H: dst_q <= AWID'({S_DATi, dst16[7:0]});
              REG_LEN_L: len_q <= LWID'({len16[15:8], S_DATi});
              REG_LEN_H: len_q <= LWID'({S_DATi, len16[7:0]});
              default: ;
            endcase
          end
          if (start && len_q != '0) begin
            state_q <= S_RD;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_q    <= 1'b0;
          end
        end
        S_RD: begin
          if (M_ACKi && stb_q) begin
            buf_q   <= M_DATi;
            stb_q   <= 1'b0;
            state_q <= S_RGAP;
          end
        end
        S_RGAP: begin
          stb_q   <= 1'b1;
          we_q    <= 1'b1;
          state_q <= S_WR;
        end
        S_WR: begin
          if (M_ACKi && stb_q) begin
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= S_WGAP;
          end
        end
        S_WGAP: begin
          src_q <= src_q + AWID'(src_inc);
          dst_q <= dst_q + AWID'(dst_inc);
          len_q <= len_dec;
          if (last) begin
            state_q <= S_IDLE;
            cyc_q   <= 1'b0;
            apend_q <= 1'b0;
          end else begin
            state_q <= S_RD;
            stb_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cyc_q   <= 1'b0;
          stb_q   <= 1'b0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spm_cdma.sv
module tb_spm_cdma;
  import spm_cdma_pkg::*;

  logic        clk, rst;
  logic [2:0]  s_adr;
  logic [7:0]  s_dat_w, s_dat_r;
  logic        s_we, s_cyc, s_stb, s_ack;
  logic [15:0] m_adr;
  logic [7:0]  m_dat_w, m_dat_r;
  logic        m_we, m_cyc, m_stb, m_ack, irq;

  int checks = 0;
  int failures = 0;

  // Slave model: read-only source memory, write-captured destination memory.
  logic [7:0] smem [0:65535];
  logic [7:0] dmem [0:65535];
  logic       ack_q;
  int         ws = 0;
  int         ws_cnt;
  logic       inj = 1'b0;
  int         cyc_cnt = 0, stb_cnt = 0, rd_beats = 0, wr_beats = 0;

  spm_cdma #(.AWID(16), .LWID(16)) dut (
    .clk(clk), .rst(rst),
    .S_ADRi(s_adr), .S_DATi(s_dat_w), .S_DATo(s_dat_r), .S_WEi(s_we),
    .S_CYCi(s_cyc), .S_STBi(s_stb), .S_ACKo(s_ack),
    .M_ADRo(m_adr), .M_DATo(m_dat_w), .M_DATi(m_dat_r), .M_WEo(m_we),
    .M_CYCo(m_cyc), .M_STBo(m_stb), .M_ACKi(m_ack), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign m_dat_r = smem[m_adr];
  // Stale ACK injection during gap cycles (cycle open, strobe low).
  assign m_ack = ack_q | (inj & m_cyc & ~m_stb);

  always @(posedge clk) begin
    if (m_cyc && m_stb && m_we && ack_q) dmem[m_adr] <= m_dat_w;
    ack_q  <= m_cyc && m_stb && (ws_cnt >= ws);
    ws_cnt <= (m_cyc && m_stb) ? ws_cnt + 1 : 0;
  end

  always @(negedge clk) begin
    if (m_cyc) cyc_cnt <= cyc_cnt + 1;
    if (m_stb) stb_cnt <= stb_cnt + 1;
    if (m_stb && m_ack) begin
      if (m_we) wr_beats <= wr_beats + 1;
      else      rd_beats <= rd_beats + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_wr(input logic [2:0] a, input logic [7:0] d);
    s_adr = a; s_dat_w = d; s_we = 1'b1; s_cyc = 1'b1; s_stb = 1'b1;
    @(posedge clk); #1;
    s_stb = 1'b0; s_we = 1'b0;
    chk("wr_ack", 64'(s_ack), 64'd1);
    @(posedge clk); #1;
    s_cyc = 1'b0;
  endtask

  task automatic wb_rd(input logic [2:0] a, output logic [7:0] d);
    s_adr = a; s_we = 1'b0; s_cyc = 1'b1; s_stb = 1'b1;
    @(posedge clk); #1;
    s_stb = 1'b0;
    d = s_dat_r;
    @(posedge clk); #1;
    s_cyc = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] d;
    wb_rd(a, d);
    chk(tag, 64'(d), 64'(exp));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (m_cyc && n < 2000) begin
      @(negedge clk); n++;
    end
    #1;
    chk(tag, 64'(n < 2000), 64'd1);
  endtask

  task automatic setup(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
    wb_wr(REG_SRC_L, src[7:0]);
    wb_wr(REG_SRC_H, src[15:8]);
    wb_wr(REG_DST_L, dst[7:0]);
    wb_wr(REG_DST_H, dst[15:8]);
    wb_wr(REG_LEN_L, len[7:0]);
    wb_wr(REG_LEN_H, len[15:8]);
  endtask

  initial begin
    int c0, s0, r0, w0, n, seen;
    s_adr = '0; s_dat_w = '0; s_we = 0; s_cyc = 0; s_stb = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {27'd0, s_dat_r, s_ack, m_adr, m_dat_w, m_we, m_cyc, m_stb, irq}, 64'd0);
    rst = 1'b0;

    // Reset asserted mid-RD.
    setup(16'h0010, 16'h0020, 16'h0001);
    wb_wr(REG_CTRL, 8'h03);
    chk("pre_rst_in_rd", {62'd0, m_cyc, m_stb}, 64'h3);
    rst = 1'b1; #1;
    chk("rst_mid_rd_bus", {61'd0, m_cyc, m_stb, irq}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) rd_chk("regs_after_rst", 3'(i), 8'h00);

    // Copy 4 bytes 0x0100 -> 0x0200.
    smem[16'h0100] = 8'h11; smem[16'h0101] = 8'h22;
    smem[16'h0102] = 8'h33; smem[16'h0103] = 8'h44;
    setup(16'h0100, 16'h0200, 16'h0004);
    c0 = cyc_cnt; r0 = rd_beats; w0 = wr_beats;
    wb_wr(REG_CTRL, 8'h0F);
    wait_idle("copy_timeout");
    chk("copy_cycles", 64'(cyc_cnt - c0), 64'd24);
    chk("copy_rd_beats", 64'(rd_beats - r0), 64'd4);
    chk("copy_wr_beats", 64'(wr_beats - w0), 64'd4);
    chk("copy_data", {32'd0, dmem[16'h0200], dmem[16'h0201], dmem[16'h0202], dmem[16'h0203]},
        64'h11223344);
    rd_chk("copy_status", REG_STATUS, 8'h02);
    chk("copy_irq", 64'(irq), 64'd1);
    rd_chk("copy_src_l", REG_SRC_L, 8'h04);
    rd_chk("copy_dst_l", REG_DST_L, 8'h04);
    rd_chk("copy_len_l", REG_LEN_L, 8'h00);
    wb_wr(REG_STATUS, 8'h02);

    // Fixed-source fill of 3 bytes.
    smem[16'h0300] = 8'hA5;
    setup(16'h0300, 16'h0400, 16'h0003);
    wb_wr(REG_CTRL, 8'h0B);
    wait_idle("fill_timeout");
    chk("fill_data", {40'd0, dmem[16'h0400], dmem[16'h0401], dmem[16'h0402]}, 64'hA5A5A5);
    rd_chk("fill_src_l", REG_SRC_L, 8'h00);
    rd_chk("fill_src_h", REG_SRC_H, 8'h03);
    rd_chk("fill_dst_l", REG_DST_L, 8'h03);
    rd_chk("fill_dst_h", REG_DST_H, 8'h04);
    wb_wr(REG_STATUS, 8'h02);

    // LEN=0 start: immediate done, no bus activity.
    s0 = stb_cnt;
    wb_wr(REG_LEN_L, 8'h00);
    wb_wr(REG_LEN_H, 8'h00);
    wb_wr(REG_CTRL, 8'h03);
    rd_chk("len0_status", REG_STATUS, 8'h02);
    chk("len0_irq", 64'(irq), 64'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("len0_no_stb", 64'(stb_cnt - s0), 64'd0);
    wb_wr(REG_STATUS, 8'h02);
    rd_chk("w1c_status", REG_STATUS, 8'h00);
    chk("w1c_irq", 64'(irq), 64'd0);

    // Abort during the second beat of LEN=8.
    for (int i = 0; i < 8; i++) smem[16'h0500 + 16'(i)] = 8'h50 + 8'(i);
    setup(16'h0500, 16'h0600, 16'h0008);
    r0 = rd_beats; w0 = wr_beats;
    wb_wr(REG_CTRL, 8'h0D);
    n = 0; seen = 0;
    while (seen < 2 && n < 500) begin
      @(negedge clk); #1;
      if (m_stb && m_ack && !m_we) seen++;
      n++;
    end
    chk("abort_wait", 64'(seen), 64'd2);
    wb_wr(REG_CTRL, 8'h1C);
    wait_idle("abort_timeout");
    chk("abort_rd_beats", 64'(rd_beats - r0), 64'd2);
    chk("abort_wr_beats", 64'(wr_beats - w0), 64'd2);
    chk("abort_data", {48'd0, dmem[16'h0600], dmem[16'h0601]}, 64'h5051);
    rd_chk("abort_status", REG_STATUS, 8'h04);
    rd_chk("abort_len_l", REG_LEN_L, 8'h06);
    chk("abort_irq", 64'(irq), 64'd0);
    wb_wr(REG_STATUS, 8'h04);
    rd_chk("abort_clr", REG_STATUS, 8'h00);

    // Wait-state slave with stale ACKs in gap cycles; writes while busy ignored.
    ws = 3; inj = 1'b1;
    smem[16'h0700] = 8'h3C; smem[16'h0701] = 8'hC3;
    setup(16'h0700, 16'h0800, 16'h0002);
    r0 = rd_beats; w0 = wr_beats;
    wb_wr(REG_CTRL, 8'h0F);
    wb_wr(REG_LEN_L, 8'h55);
    wb_wr(REG_CTRL, 8'h0F);
    rd_chk("ws_busy", REG_STATUS, 8'h01);
    wait_idle("ws_timeout");
    chk("ws_rd_beats", 64'(rd_beats - r0), 64'd2);
    chk("ws_wr_beats", 64'(wr_beats - w0), 64'd2);
    chk("ws_data", {48'd0, dmem[16'h0800], dmem[16'h0801]}, 64'h3CC3);
    rd_chk("ws_status", REG_STATUS, 8'h02);
    rd_chk("ws_len_l", REG_LEN_L, 8'h00);
    repeat (10) @(negedge clk);
    #1;
    chk("ws_no_restart", 64'(m_cyc), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
